// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO. A single radix-2 datapath
// works on operand magnitudes; sign correction is applied once, in the FIX state.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_orig_a;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_sign_q;
    logic                 r_sign_r;
    logic                 r_dz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_dbz;

    // op[1] selects divide, op[0] selects unsigned.
    logic                 w_issue;
    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_rem_diff;
    logic                 w_q_bit;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_hi_res;
    logic [WIDTH-1:0]     w_lo_res;

    assign w_issue  = start & ~flush;
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & op_a[WIDTH-1];
    assign w_b_neg  = w_signed & op_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -op_a : op_a;
    assign w_b_mag  = w_b_neg ? -op_b : op_b;

    // Multiply: accumulator holds {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: accumulator holds {partial remainder, dividend bits / quotient bits}.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_diff = w_rem_sh - {1'b0, r_b};
    assign w_q_bit    = ~w_rem_diff[WIDTH];
    assign w_div_next = {(w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_q_bit};

    assign w_prod = r_sign_q ? -r_acc : r_acc;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        w_hi_res = w_prod[2*WIDTH-1:WIDTH];
        w_lo_res = w_prod[WIDTH-1:0];
        if (r_dz) begin
            w_hi_res = r_orig_a;
            w_lo_res = '1;
        end else if (r_op[1]) begin
            w_lo_res = r_sign_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_hi_res = r_sign_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_CALC;
            S_CALC: begin
                if (flush)              w_state_nxt = S_IDLE;
                else if (r_cnt == '0)   w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_b) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_op     <= '0;
            r_b      <= '0;
            r_orig_a <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_op     <= op;
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_b      <= w_b_mag;
                        r_orig_a <= op_a;
                        r_sign_q <= w_a_neg ^ w_b_neg;
                        r_sign_r <= w_a_neg;
                        r_dz     <= op[1] & (op_b == '0);
                        r_cnt    <= CNT_INIT;
                    end else if (!start) begin
                        // A start squashed by flush still blocks same-cycle mthi/mtlo.
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_acc <= r_op[1] ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_hi   <= w_hi_res;
                        r_lo   <= w_lo_res;
                        r_done <= 1'b1;
                        r_dbz  <= r_dz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == S_CALC) || (r_state == S_FIX);
    assign stall       = busy & (start | rd_req | mthi | mtlo);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected HI/LO/div_by_zero,
// an independent monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        rd_req = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_req(rd_req),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every done pulse against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check({mon_e.tag, "_hi"}, 64'(hi), 64'(mon_e.hi));
                    check({mon_e.tag, "_lo"}, 64'(lo), 64'(mon_e.lo));
                    check({mon_e.tag, "_dz"}, 64'(div_by_zero), 64'(mon_e.dz));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic expect_done,
                            input logic [31:0] eh, input logic [31:0] el, input logic edz);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        if (expect_done) sb_q.push_back('{tag, eh, el, edz});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh,
                          input logic [31:0] el, input logic edz);
        int n;
        start_op(tag, o, a, b, 1'b1, eh, el, edz);
        wait_idle(n);
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
    endtask

    initial begin
        int n;
        int seen;

        @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset_b = 1'b1;

        @(negedge clk);
        rd_req = 1'b1;
        #1;
        check("idle_rdreq_stall", 64'(stall), 64'd0);
        rd_req = 1'b0;

        @(negedge clk);
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        @(negedge clk);
        check("done_width", 64'(done), 64'd0);

        run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("divu_z", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
        run_op("div_z", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
        run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);

        // Back-to-back: second start is presented in the done cycle of the first.
        run_op("multu_3_5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        run_op("mult_m1_m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0);

        // start together with flush in IDLE is ignored.
        start = 1'b1;
        flush = 1'b1;
        op    = OP_MULTU;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("start_flush_busy", 64'(busy), 64'd0);

        @(negedge clk);
        mtlo  = 1'b1;
        wdata = 32'h0000ABCD;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h0000ABCD);
        @(negedge clk);
        mthi  = 1'b1;
        wdata = 32'h00001234;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h00001234);
        check("mthi_lo_kept", 64'(lo), 64'h0000ABCD);

        // Flush on busy cycle 10.
        @(negedge clk);
        start_op("divu_flushed", OP_DIVU, 32'd100, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'h00001234);
        check("flush_lo", 64'(lo), 64'h0000ABCD);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("flush_no_done", 64'(seen), 64'd0);

        // Requests while busy stall and are ignored.
        start_op("divu_stall", OP_DIVU, 32'd1003, 32'd10, 1'b1, 32'd3, 32'd100, 1'b0);
        start = 1'b1;
        op    = OP_MULT;
        op_a  = 32'd9;
        op_b  = 32'd9;
        #1;
        check("busy_start_stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        start  = 1'b0;
        rd_req = 1'b1;
        #1;
        check("busy_rdreq_stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        mtlo   = 1'b1;
        wdata  = 32'h00005555;
        #1;
        check("busy_mtlo_stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check("busy_mtlo_lo_kept", 64'(lo), 64'h0000ABCD);
        check("busy_mtlo_hi_kept", 64'(hi), 64'h00001234);
        wait_idle(n);
        check("divu_stall_remaining_busy", 64'(n), 64'd30);

        // Asynchronous reset mid-CALC.
        start_op("multu_reset", OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        reset_b = 1'b0;
        #1;
        check("async_rst_hi", 64'(hi), 64'd0);
        check("async_rst_lo", 64'(lo), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        run_op("multu_after_rst", OP_MULTU, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
